snes_pad_responder: RTL

//  Device-side end of the serial SNES/GameTank joypad protocol, the responder counterpart of controller_snes.

---
 rtl/snes_pad_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/snes_pad_responder.sv
// Device-side SNES joypad responder. It answers a console's latch/clock pins with an active-low serial
// button stream, using synchronised and glitch-filtered pins and a timeout that drops a stalled frame.
module snes_pad_responder #(
    parameter int NBITS   = 16,
    parameter int FILT    = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] buttons,
    input  logic        joy_strb,
    input  logic        joy_clk,
    output logic        joy_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NBITS - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    // Bit 1 is joy_clk, which idles high. Bit 0 is joy_strb, which idles low.
    localparam logic [1:0] PIN_IDLE = 2'b10;

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT} state_e;

    logic [1:0]       sync1_q, sync2_q, filt_q;
    logic [FW-1:0]    fcnt_q [2];
    logic             clk_prev_q;
    state_e           state_q, state_d;
    logic [NBITS-1:0] sr_q, sr_d, load_val;
    logic [CW-1:0]    count_q, count_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             done_q, done_d;
    logic             strb_f, clk_rise;

    // A new pin level must persist for FILT consecutive synchronised samples before filt_q takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
            sync1_q    <= PIN_IDLE;
            sync2_q    <= PIN_IDLE;
            filt_q     <= PIN_IDLE;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            sync1_q    <= {joy_clk, joy_strb};
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FILT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FW'(1);
                end
            end
        end
    end

    assign strb_f   = filt_q[0];
    assign clk_rise = filt_q[1] & ~clk_prev_q;

    always_comb begin
        load_val       = '1;
        load_val[11:0] = ~buttons;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        sr_d    = sr_q;
        count_d = count_q;
        tmo_d   = '0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strb_f) state_d = LATCH;
            end
            LATCH: begin
                sr_d    = load_val;
                count_d = '0;
                if (!strb_f) state_d = SHIFT;
            end
            SHIFT: begin
                if (strb_f) begin
                    state_d = LATCH;
                    sr_d    = load_val;
                    count_d = '0;
                end else if (clk_rise) begin
                    sr_d    = {1'b1, sr_q[NBITS-1:1]};
                    count_d = count_q + CW'(1);
                    if (count_q == CNT_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // A stalled console leaves the line released rather than holding a stale bit.
                    state_d = IDLE;
                    sr_d    = '1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sr_q    <= '1;
            count_q <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
        end
    end

    assign joy_data   = sr_q[0];
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;

endmodule
